// File: rtl/db_pkg.sv
// rtl/db_pkg.sv - shared types and command priority for the debug target model
package db_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tgt_state_t;

  // Enum order is the execution priority: lower value wins when several strobes coincide.
  typedef enum logic [3:0] {
    CMD_NONE   = 4'd0,
    CMD_RESET  = 4'd1,
    CMD_MEM_WR = 4'd2,
    CMD_REG_WR = 4'd3,
    CMD_MEM_RD = 4'd4,
    CMD_REG_RD = 4'd5,
    CMD_PAUSE  = 4'd6,
    CMD_RESUME = 4'd7,
    CMD_STEP   = 4'd8
  } cmd_t;

  // req bit 7 is reset (highest) down to bit 0 step (lowest).
  function automatic cmd_t pick_cmd(input logic [7:0] req);
    cmd_t c;
    if (req[7])      c = CMD_RESET;
    else if (req[6]) c = CMD_MEM_WR;
    else if (req[5]) c = CMD_REG_WR;
    else if (req[4]) c = CMD_MEM_RD;
    else if (req[3]) c = CMD_REG_RD;
    else if (req[2]) c = CMD_PAUSE;
    else if (req[1]) c = CMD_RESUME;
    else if (req[0]) c = CMD_STEP;
    else             c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/db_target_model_if.sv
// rtl/db_target_model_if.sv - controller-to-target command/status bundle
interface db_target_model_if;
  logic        valid;
  logic        pause;
  logic        resume;
  logic        step;
  logic        reset;
  logic        mem_rd;
  logic        mem_wr;
  logic        reg_rd;
  logic        reg_wr;
  logic [1:0]  mem_size;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_rd;
  logic        mcu_busy;
  logic        error;
  logic [31:0] pc;
  logic        paused;

  modport master (
    output valid, pause, resume, step, reset, mem_rd, mem_wr, reg_rd, reg_wr,
    output mem_size, addr, d_in,
    input  d_rd, mcu_busy, error, pc, paused
  );

  modport slave (
    input  valid, pause, resume, step, reset, mem_rd, mem_wr, reg_rd, reg_wr,
    input  mem_size, addr, d_in,
    output d_rd, mcu_busy, error, pc, paused
  );
endinterface

// File: rtl/db_mem_lane.sv
// rtl/db_mem_lane.sv - byte-lane write merge, read extract and size/alignment check
module db_mem_lane
  import db_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] rdata,
  output logic        size_err
);

  always_comb begin
    merged   = old_word;
    rdata    = '0;
    size_err = 1'b0;
    case (mem_size_t'(size))
      SIZE_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        rdata[7:0]                  = old_word[{lane, 3'b000} +: 8];
      end
      SIZE_HALF: begin
        size_err                         = lane[0];
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        rdata[15:0]                      = old_word[{lane[1], 4'b0000} +: 16];
      end
      SIZE_WORD: begin
        size_err = |lane;
        merged   = wdata;
        rdata    = old_word;
      end
      default: size_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/db_target_model.sv
// rtl/db_target_model.sv - behavioural MCU target answering debug_controller commands
module db_target_model
  import db_pkg::*;
#(
  parameter int          MEM_WORDS    = 64,
  parameter int          RF_SIZE      = 32,
  parameter int          DELAY_CYCLES = 10,
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter logic [31:0] PC_RESET     = 32'd0
) (
  input logic               clk,
  input logic               rst_n,
  db_target_model_if.slave  bus
);

  localparam int CNT_W = (DELAY_CYCLES == 0) ? 1 : $clog2(DELAY_CYCLES + 1);
  localparam int IDX_W = (MEM_WORDS < 2) ? 1 : $clog2(MEM_WORDS);
  localparam int RF_W  = (RF_SIZE < 2) ? 1 : $clog2(RF_SIZE);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
  localparam logic [31:0] RF_LIMIT  = 32'(RF_SIZE);

  tgt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             paused_q, paused_d;
  logic [31:0]      d_rd_q, d_rd_d;
  logic             error_q, error_d;

  // Contents survive rst_n; only power-up clears them.
  logic [31:0] mem_q [MEM_WORDS] = '{default: '0};
  logic [31:0] rf_q  [RF_SIZE]   = '{default: '0};

  logic [IDX_W-1:0] mem_idx;
  logic [RF_W-1:0]  rf_idx;
  logic [31:0]      lane_merged, lane_rdata;
  logic             lane_err;
  logic             mem_bad, rf_bad, accept, mem_we, rf_we;
  cmd_t             cmd;

  assign mem_idx = bus.addr[IDX_W+1:2];
  assign rf_idx  = bus.addr[RF_W-1:0];
  assign mem_bad = lane_err | (bus.addr >= MEM_BYTES);
  assign rf_bad  = bus.addr >= RF_LIMIT;
  assign accept  = bus.valid & (state_q == IDLE);

  db_mem_lane u_lane (
    .size     (bus.mem_size),
    .lane     (bus.addr[1:0]),
    .old_word (mem_q[mem_idx]),
    .wdata    (bus.d_in),
    .merged   (lane_merged),
    .rdata    (lane_rdata),
    .size_err (lane_err)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = paused_q ? pc_q : pc_q + PC_STEP;
    paused_d = paused_q;
    d_rd_d   = d_rd_q;
    error_d  = error_q;
    mem_we   = 1'b0;
    rf_we    = 1'b0;
    cmd      = pick_cmd({bus.reset, bus.mem_wr, bus.reg_wr, bus.mem_rd,
                         bus.reg_rd, bus.pause, bus.resume, bus.step});
    if (accept) begin
      if (DELAY_CYCLES != 0) begin
        state_d = BUSY;
        cnt_d   = CNT_W'(DELAY_CYCLES);
      end
      error_d = 1'b0;
      case (cmd)
        CMD_RESET: begin
          pc_d     = PC_RESET;
          paused_d = 1'b0;
        end
        CMD_MEM_WR: begin
          if (mem_bad) error_d = 1'b1;
          else         mem_we  = 1'b1;
        end
        CMD_REG_WR: begin
          if (rf_bad) error_d = 1'b1;
          else        rf_we   = (rf_idx != '0);
        end
        CMD_MEM_RD: begin
          if (mem_bad) error_d = 1'b1;
          else         d_rd_d  = lane_rdata;
        end
        CMD_REG_RD: begin
          if (rf_bad)              error_d = 1'b1;
          else if (rf_idx == '0)   d_rd_d  = '0;
          else                     d_rd_d  = rf_q[rf_idx];
        end
        CMD_PAUSE:  paused_d = 1'b1;
        CMD_RESUME: begin
          paused_d = 1'b0;
          pc_d     = pc_q + PC_STEP;
        end
        CMD_STEP: if (paused_q) pc_d = pc_q + PC_STEP;
        default: ;
      endcase
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pc_q     <= PC_RESET;
      paused_q <= 1'b0;
      d_rd_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      paused_q <= paused_d;
      d_rd_q   <= d_rd_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= lane_merged;
    if (rf_we)  rf_q[rf_idx]   <= bus.d_in;
  end

  assign bus.d_rd     = d_rd_q;
  assign bus.error    = error_q;
  assign bus.pc       = pc_q;
  assign bus.paused   = paused_q;
  assign bus.mcu_busy = bus.valid | (state_q == BUSY);

endmodule
